mem2io_mmio_bridge: RTL and testbench

// - Parametrised CPU<->SRAM/IO bridge: passes CPU data to SRAM; decodes a small MMIO window at the top of
//   the address space; drives NUM_HEX 7-seg digits and an LED register; returns debounced switches.
// - Sits between the CPU bus and the SRAM pins at top level.
// - Adds to the prior bridge: switch sync/debounce, a sticky switch-change flag, a cycle counter, and true 7-seg encoding.

---
 rtl/mem2io_pkg.sv | 16 +
 rtl/hex_to_seg7.sv | 11 +
 rtl/mem2io_mmio_bridge.sv | 165 ++++++++++++++++
 tb/tb_mem2io_mmio_bridge.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem2io_pkg.sv
// Shared constants for the CPU/SRAM/IO bridge: MMIO address map and 7-seg glyphs.
package mem2io_pkg;

  // MMIO window at the top of the decoded 16-bit address space
  localparam logic [15:0] ADDR_SW_HEX = 16'hFFFF;
  localparam logic [15:0] ADDR_LED    = 16'hFFFE;
  localparam logic [15:0] ADDR_STATUS = 16'hFFFD;
  localparam logic [15:0] ADDR_CYCLE  = 16'hFFFC;

  // Active-low segment patterns {g,f,e,d,c,b,a} for hex digits 0-F
  localparam logic [6:0] SEG7_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// One hex nibble to one active-low 7-segment digit, purely combinational.
module hex_to_seg7
  import mem2io_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG7_LUT[hex_i];

endmodule

// File: rtl/mem2io_mmio_bridge.sv
// CPU <-> SRAM bridge with a small MMIO window: hex display, LEDs, debounced
// switches with a sticky change flag, and a free-running cycle counter.
module mem2io_mmio_bridge
  import mem2io_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 20,
  parameter int NUM_HEX    = 4,
  parameter int LED_W      = 12,
  parameter int DEB_CYCLES = 50000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [ADDR_W-1:0]    ADDR,
  input  logic                 CE,
  input  logic                 UB,
  input  logic                 LB,
  input  logic                 OE,
  input  logic                 WE,
  input  logic [DATA_W-1:0]    Switches,
  input  logic [DATA_W-1:0]    Data_from_CPU,
  input  logic [DATA_W-1:0]    Data_from_SRAM,
  output logic [DATA_W-1:0]    Data_to_CPU,
  output logic [DATA_W-1:0]    Data_to_SRAM,
  output logic [NUM_HEX*7-1:0] HEX,
  output logic [LED_W-1:0]     LED
);

  localparam int                CNT_W   = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0]  DEB_MAX = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [DATA_W-1:0] CYC_ONE = DATA_W'(1);

  // Only the low 16 address bits take part in decode
  logic [15:0] addr_lo;
  logic        unused_addr_hi;
  assign addr_lo        = ADDR[15:0];
  assign unused_addr_hi = ^ADDR[ADDR_W-1:16];

  logic rd, wr;
  logic sel_sw, sel_led, sel_status, sel_cycle;
  assign rd         = ~CE & ~OE & WE;
  assign wr         = ~CE & ~WE;
  assign sel_sw     = (addr_lo == ADDR_SW_HEX);
  assign sel_led    = (addr_lo == ADDR_LED);
  assign sel_status = (addr_lo == ADDR_STATUS);
  assign sel_cycle  = (addr_lo == ADDR_CYCLE);

  logic [DATA_W-1:0] hex_q, hex_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DATA_W-1:0] sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] deb_q, deb_d;
  logic              chg_q, chg_d;
  logic              rd_prev_q;
  logic              rd_status;
  logic [DATA_W-1:0] cyc_q;
  logic [DATA_W-1:0] lane_mask;

  // Byte-lane merge for the writable MMIO registers
  assign lane_mask = {{(DATA_W-8){~UB}}, {8{~LB}}};

  // Next value of hex_data and LED from a write to their addresses
  always_comb begin
    hex_d = hex_q;
    led_d = led_q;
    if (wr && sel_sw) begin
      hex_d = (hex_q & ~lane_mask) | (Data_from_CPU & lane_mask);
    end
    if (wr && sel_led) begin
      led_d = (led_q & ~lane_mask[LED_W-1:0]) | (Data_from_CPU[LED_W-1:0] & lane_mask[LED_W-1:0]);
    end
  end

  // Bus-writable registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      hex_q <= '0;
      led_q <= '0;
    end else begin
      hex_q <= hex_d;
      led_q <= led_d;
    end
  end

  // Debounce: restart the count on any change of the synchronised value;
  // the debounced value is taken on the cycle the count lands on its top.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != DEB_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
    if (cnt_d == DEB_MAX) begin
      deb_d = sync2_q;
    end
  end

  // Switch synchroniser, change detector and debounce state
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      deb_q   <= '0;
    end else begin
      sync1_q <= Switches;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
    end
  end

  // Sticky change flag: cleared only on the first cycle of a STATUS read,
  // and a simultaneous debounce update keeps it set.
  assign rd_status = rd & sel_status;
  assign chg_d     = (deb_d != deb_q) | (chg_q & ~(rd_status & ~rd_prev_q));

  // Change flag and read-edge tracking
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      chg_q     <= 1'b0;
      rd_prev_q <= 1'b0;
    end else begin
      chg_q     <= chg_d;
      rd_prev_q <= rd_status;
    end
  end

  // Free-running cycle counter
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_q + CYC_ONE;
    end
  end

  // Read mux: MMIO registers over SRAM, zero when not reading
  always_comb begin
    Data_to_CPU = '0;
    if (rd) begin
      if (sel_sw)          Data_to_CPU = deb_q;
      else if (sel_led)    Data_to_CPU = DATA_W'(led_q);
      else if (sel_status) Data_to_CPU = DATA_W'(chg_q);
      else if (sel_cycle)  Data_to_CPU = cyc_q;
      else                 Data_to_CPU = Data_from_SRAM;
    end
  end

  assign Data_to_SRAM = Data_from_CPU;
  assign LED          = led_q;

  for (genvar g = 0; g < NUM_HEX; g++) begin : g_digit
    hex_to_seg7 u_seg (
      .hex_i (hex_q[4*g +: 4]),
      .seg_o (HEX[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_mem2io_mmio_bridge.sv
// Self-checking bench for mem2io_mmio_bridge with a fast debounce (4 cycles).
module tb_mem2io_mmio_bridge;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 20;
  localparam int NUM_HEX = 4;
  localparam int LED_W = 12;
  localparam int DEB = 4;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic [ADDR_W-1:0] ADDR = '0;
  logic              CE = 1'b1, UB = 1'b1, LB = 1'b1, OE = 1'b1, WE = 1'b1;
  logic [DATA_W-1:0] Switches = '0, Data_from_CPU = '0, Data_from_SRAM = '0;
  logic [DATA_W-1:0] Data_to_CPU, Data_to_SRAM;
  logic [NUM_HEX*7-1:0] HEX;
  logic [LED_W-1:0]  LED;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  mem2io_mmio_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_HEX(NUM_HEX), .LED_W(LED_W), .DEB_CYCLES(DEB)
  ) dut (
    .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .CE(CE), .UB(UB), .LB(LB), .OE(OE), .WE(WE),
    .Switches(Switches), .Data_from_CPU(Data_from_CPU), .Data_from_SRAM(Data_from_SRAM),
    .Data_to_CPU(Data_to_CPU), .Data_to_SRAM(Data_to_SRAM), .HEX(HEX), .LED(LED)
  );

  // ---------------- reference model ----------------
  // Debounced value = switch value once DEB consecutive raw samples agree,
  // seen two cycles late through the synchroniser.
  logic [15:0] m_hex = '0, m_deb = '0, m_cyc = '0;
  logic [11:0] m_led = '0;
  logic        m_chg = 1'b0, m_rdst_prev = 1'b0;
  logic [15:0] hist [0:DEB+1];

  always @(posedge Clk) begin : model
    logic        rd_m, wr_m, rdst, all_eq;
    logic [15:0] a, nd;
    a    = ADDR[15:0];
    rd_m = !CE && !OE && WE;
    wr_m = !CE && !WE;
    if (!Reset) begin
      m_hex <= '0; m_led <= '0; m_chg <= 1'b0; m_cyc <= '0; m_deb <= '0; m_rdst_prev <= 1'b0;
      for (int i = 0; i <= DEB+1; i++) hist[i] <= '0;
    end else begin
      all_eq = 1'b1;
      for (int i = 2; i <= DEB; i++) if (hist[i] !== hist[1]) all_eq = 1'b0;
      nd = all_eq ? hist[1] : m_deb;
      hist[0] <= Switches;
      for (int i = 1; i <= DEB+1; i++) hist[i] <= hist[i-1];
      m_deb <= nd;
      rdst = rd_m && (a == 16'hFFFD);
      m_rdst_prev <= rdst;
      if (nd != m_deb) m_chg <= 1'b1;
      else if (rdst && !m_rdst_prev) m_chg <= 1'b0;
      if (wr_m && a == 16'hFFFF) begin
        if (!LB) m_hex[7:0]  <= Data_from_CPU[7:0];
        if (!UB) m_hex[15:8] <= Data_from_CPU[15:8];
      end
      if (wr_m && a == 16'hFFFE) begin
        if (!LB) m_led[7:0]  <= Data_from_CPU[7:0];
        if (!UB) m_led[11:8] <= Data_from_CPU[11:8];
      end
      m_cyc <= m_cyc + 16'd1;
    end
  end

  function automatic logic [6:0] seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [27:0] exp_hex(input logic [15:0] v);
    return {seg(v[15:12]), seg(v[11:8]), seg(v[7:4]), seg(v[3:0])};
  endfunction

  function automatic logic [15:0] exp_rd();
    if (!(!CE && !OE && WE)) return 16'h0;
    case (ADDR[15:0])
      16'hFFFF: return m_deb;
      16'hFFFE: return {4'h0, m_led};
      16'hFFFD: return {15'h0, m_chg};
      16'hFFFC: return m_cyc;
      default:  return Data_from_SRAM;
    endcase
  endfunction

  // ---------------- bus helpers ----------------
  task automatic step();
    @(posedge Clk); #3;
  endtask

  task automatic bus_idle();
    CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1; ADDR = '0;
  endtask

  task automatic set_read(input logic [19:0] a);
    CE = 1'b0; OE = 1'b0; WE = 1'b1; UB = 1'b0; LB = 1'b0; ADDR = a; #1;
  endtask

  task automatic set_write(input logic [19:0] a, input logic [15:0] d, input logic ub, input logic lb);
    CE = 1'b0; OE = 1'b1; WE = 1'b0; UB = ub; LB = lb; ADDR = a; Data_from_CPU = d; #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b0;
    set_write(20'hFFFFF, 16'hABCD, 1'b0, 1'b0);
    step();
    Data_from_SRAM = 16'h5AA5;
    set_read(20'h00123);
    checks++; if (Data_to_CPU !== 16'h5AA5) begin failures++; $display("FAIL reset_rd_mux: got %h want %h", Data_to_CPU, 16'h5AA5); end
    step(); #1;
    checks++; if (HEX !== {4{7'h40}}) begin failures++; $display("FAIL reset_hex: got %h want %h", HEX, {4{7'h40}}); end
    checks++; if (LED !== 12'h000) begin failures++; $display("FAIL reset_led: got %h want 000", LED); end
    Reset = 1'b1;
    set_read(20'hFFFFC);
    for (int i = 0; i < 4; i++) begin
      checks++; if (Data_to_CPU !== 16'(i)) begin failures++; $display("FAIL reset_cycle%0d: got %h want %h", i, Data_to_CPU, 16'(i)); end
      step(); #1;
    end
    bus_idle();
  endtask

  task automatic test_byte_write();
    set_write(20'hFFFFF, 16'h1234, 1'b0, 1'b0);
    checks++; if (Data_to_SRAM !== 16'h1234) begin failures++; $display("FAIL sram_wdata: got %h want 1234", Data_to_SRAM); end
    step(); bus_idle(); #1;
    checks++; if (HEX !== {7'h79, 7'h24, 7'h30, 7'h19}) begin failures++; $display("FAIL hex_1234: got %h want %h", HEX, {7'h79, 7'h24, 7'h30, 7'h19}); end
    set_write(20'hFFFFF, 16'hABCD, 1'b1, 1'b0);
    step(); bus_idle(); #1;
    checks++; if (HEX !== {7'h79, 7'h24, 7'h46, 7'h21}) begin failures++; $display("FAIL hex_12CD: got %h want %h", HEX, {7'h79, 7'h24, 7'h46, 7'h21}); end
    set_write(20'hFFFFF, 16'h9876, 1'b1, 1'b1);
    step(); bus_idle(); #1;
    checks++; if (HEX !== {7'h79, 7'h24, 7'h46, 7'h21}) begin failures++; $display("FAIL hex_nolane: got %h want %h", HEX, {7'h79, 7'h24, 7'h46, 7'h21}); end
  endtask

  task automatic test_debounce();
    logic [15:0] want;
    repeat (8) step();
    Switches = 16'h00F0;
    set_read(20'hFFFFF);
    for (int i = 0; i <= 8; i++) begin
      want = (i >= 2 + DEB) ? 16'h00F0 : 16'h0000;
      checks++; if (Data_to_CPU !== want) begin failures++; $display("FAIL deb_cyc%0d: got %h want %h", i, Data_to_CPU, want); end
      step(); #1;
    end
    bus_idle();
  endtask

  task automatic test_chg();
    step();
    set_read(20'hFFFFD);
    checks++; if (Data_to_CPU !== 16'h0001) begin failures++; $display("FAIL chg_set: got %h want 0001", Data_to_CPU); end
    step(); bus_idle(); step();
    set_read(20'hFFFFD);
    checks++; if (Data_to_CPU !== 16'h0000) begin failures++; $display("FAIL chg_clr: got %h want 0000", Data_to_CPU); end
    step(); bus_idle();
  endtask

  task automatic test_glitch();
    step();
    Switches = 16'hFFFF;
    step(); step();
    Switches = 16'h00F0;
    repeat (10) step();
    set_read(20'hFFFFF);
    checks++; if (Data_to_CPU !== 16'h00F0) begin failures++; $display("FAIL glitch_sw: got %h want 00F0", Data_to_CPU); end
    step(); bus_idle(); step();
    set_read(20'hFFFFD);
    checks++; if (Data_to_CPU !== 16'h0000) begin failures++; $display("FAIL glitch_chg: got %h want 0000", Data_to_CPU); end
    step(); bus_idle();
  endtask

  task automatic test_chg_coincident();
    step();
    Switches = 16'h5A5A;
    repeat (DEB + 1) step();
    set_read(20'hFFFFD);
    checks++; if (Data_to_CPU !== 16'h0000) begin failures++; $display("FAIL coin_pre: got %h want 0000", Data_to_CPU); end
    for (int i = 0; i < 3; i++) begin
      step(); #1;
      checks++; if (Data_to_CPU !== 16'h0001) begin failures++; $display("FAIL coin_hold%0d: got %h want 0001", i, Data_to_CPU); end
    end
    bus_idle(); step();
    set_read(20'hFFFFF);
    checks++; if (Data_to_CPU !== 16'h5A5A) begin failures++; $display("FAIL coin_sw: got %h want 5A5A", Data_to_CPU); end
    step(); bus_idle(); step();
    set_read(20'hFFFFD);
    checks++; if (Data_to_CPU !== 16'h0001) begin failures++; $display("FAIL coin_reread: got %h want 0001", Data_to_CPU); end
    step(); bus_idle(); step();
    set_read(20'hFFFFD);
    checks++; if (Data_to_CPU !== 16'h0000) begin failures++; $display("FAIL coin_clr: got %h want 0000", Data_to_CPU); end
    step(); bus_idle();
  endtask

  task automatic test_passthrough();
    for (int i = 0; i < 6; i++) begin
      Data_from_SRAM = 16'($urandom);
      Data_from_CPU  = 16'($urandom);
      set_read(20'h00010);
      checks++; if (Data_to_CPU !== Data_from_SRAM) begin failures++; $display("FAIL sram_rd%0d: got %h want %h", i, Data_to_CPU, Data_from_SRAM); end
      checks++; if (Data_to_SRAM !== Data_from_CPU) begin failures++; $display("FAIL sram_wr%0d: got %h want %h", i, Data_to_SRAM, Data_from_CPU); end
      step();
    end
    CE = 1'b1; #1;
    checks++; if (Data_to_CPU !== 16'h0000) begin failures++; $display("FAIL no_rd: got %h want 0000", Data_to_CPU); end
    set_write(20'hFFFFC, 16'hFFFF, 1'b0, 1'b0); step();
    set_write(20'hFFFFD, 16'hFFFF, 1'b0, 1'b0); step();
    bus_idle(); #1;
    checks++; if (HEX !== exp_hex(m_hex)) begin failures++; $display("FAIL ro_hex: got %h want %h", HEX, exp_hex(m_hex)); end
    checks++; if (LED !== m_led) begin failures++; $display("FAIL ro_led: got %h want %h", LED, m_led); end
    set_read(20'hFFFFD);
    checks++; if (Data_to_CPU !== 16'h0000) begin failures++; $display("FAIL ro_chg: got %h want 0000", Data_to_CPU); end
    step(); bus_idle();
  endtask

  task automatic test_random();
    logic [15:0] sw_tab [4];
    logic [15:0] want;
    sw_tab[0] = 16'h0000; sw_tab[1] = 16'h00F0; sw_tab[2] = 16'hA5A5; sw_tab[3] = 16'hFFFF;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: ADDR = {4'($urandom), 16'hFFFF};
        1: ADDR = {4'($urandom), 16'hFFFE};
        2: ADDR = {4'($urandom), 16'hFFFD};
        3: ADDR = {4'($urandom), 16'hFFFC};
        default: ADDR = 20'($urandom);
      endcase
      CE = ($urandom_range(0, 7) == 0);
      WE = 1'($urandom); OE = 1'($urandom); UB = 1'($urandom); LB = 1'($urandom);
      Data_from_CPU = 16'($urandom); Data_from_SRAM = 16'($urandom);
      if ($urandom_range(0, 11) == 0) Switches = sw_tab[$urandom_range(0, 3)];
      #1;
      want = exp_rd();
      checks++; if (Data_to_CPU !== want) begin failures++; $display("FAIL rnd_rd%0d: got %h want %h", i, Data_to_CPU, want); end
      checks++; if (HEX !== exp_hex(m_hex)) begin failures++; $display("FAIL rnd_hex%0d: got %h want %h", i, HEX, exp_hex(m_hex)); end
      checks++; if (LED !== m_led) begin failures++; $display("FAIL rnd_led%0d: got %h want %h", i, LED, m_led); end
      checks++; if (Data_to_SRAM !== Data_from_CPU) begin failures++; $display("FAIL rnd_sram%0d: got %h want %h", i, Data_to_SRAM, Data_from_CPU); end
      step();
    end
    bus_idle();
  endtask

  task automatic test_wrap();
    int n;
    set_write(20'hFFFFE, 16'hFFFF, 1'b0, 1'b0);
    step(); bus_idle(); #1;
    checks++; if (LED !== 12'hFFF) begin failures++; $display("FAIL led_ffff: got %h want FFF", LED); end
    set_read(20'hFFFFE);
    checks++; if (Data_to_CPU !== 16'h0FFF) begin failures++; $display("FAIL led_rd: got %h want 0FFF", Data_to_CPU); end
    step();
    set_read(20'hFFFFC);
    checks++; if (Data_to_CPU !== m_cyc) begin failures++; $display("FAIL cyc_track: got %h want %h", Data_to_CPU, m_cyc); end
    n = 16'hFFFF - m_cyc;
    repeat (n) step();
    #1;
    checks++; if (Data_to_CPU !== 16'hFFFF) begin failures++; $display("FAIL cyc_max: got %h want FFFF", Data_to_CPU); end
    step(); #1;
    checks++; if (Data_to_CPU !== 16'h0000) begin failures++; $display("FAIL cyc_wrap: got %h want 0000", Data_to_CPU); end
    bus_idle();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byte_write();
    test_debounce();
    test_chg();
    test_glitch();
    test_chg_coincident();
    test_passthrough();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
